// File: rtl/spi_header_assembler.sv
// Collects bytes from an SPI slave into one fixed-length block header frame
// and holds the completed header stable until the miner acknowledges it.
module spi_header_assembler #(
  parameter int HEADER_BYTES = 80,
  parameter int CNT_W        = 7
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      chip_enable,
  input  logic                      byte_valid,
  input  logic [7:0]                byte_data,
  input  logic                      header_ack,
  output logic [HEADER_BYTES*8-1:0] header,
  output logic                      header_valid,
  output logic                      frame_error,
  output logic                      busy_drop,
  output logic [CNT_W-1:0]          byte_count,
  output logic [7:0]                frame_count
);

  localparam int HDR_W = HEADER_BYTES * 8;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(HEADER_BYTES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RECV    = 3'd1,
    ST_FULL    = 3'd2,
    ST_HOLD    = 3'd3,
    ST_DISCARD = 3'd4
  } state_t;

  state_t             state_r;
  state_t             state_s;
  logic [HDR_W-1:0]   header_r;
  logic [HDR_W-1:0]   header_s;
  logic               valid_r;
  logic               valid_s;
  logic               ferr_r;
  logic               ferr_s;
  logic               bdrop_r;
  logic               bdrop_s;
  logic [CNT_W-1:0]   cnt_r;
  logic [CNT_W-1:0]   cnt_s;
  logic [7:0]         fcnt_r;
  logic [7:0]         fcnt_s;

  // Next-state and next-output logic; pulses default low every cycle.
  always_comb begin
    state_s  = state_r;
    header_s = header_r;
    valid_s  = valid_r;
    ferr_s   = 1'b0;
    bdrop_s  = 1'b0;
    cnt_s    = cnt_r;
    fcnt_s   = fcnt_r;
    case (state_r)
      ST_IDLE: begin
        if (!chip_enable) begin
          state_s = ST_RECV;
          cnt_s   = '0;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_RECV: begin
        if (byte_valid) begin
          header_s = {header_r[HDR_W-9:0], byte_data};
          cnt_s    = cnt_r + CNT_ONE;
        end else begin
          header_s = header_r;
        end
        // The frame end is judged on the count including this cycle's byte.
        if (cnt_s == CNT_FULL) begin
          if (chip_enable) begin
            state_s = ST_HOLD;
            valid_s = 1'b1;
            fcnt_s  = fcnt_r + 8'd1;
          end else begin
            state_s = ST_FULL;
          end
        end else if (chip_enable) begin
          ferr_s  = 1'b1;
          state_s = ST_IDLE;
        end else begin
          state_s = ST_RECV;
        end
      end
      ST_FULL: begin
        if (byte_valid) begin
          ferr_s  = 1'b1;
          state_s = ST_DISCARD;
        end else if (chip_enable) begin
          state_s = ST_HOLD;
          valid_s = 1'b1;
          fcnt_s  = fcnt_r + 8'd1;
        end else begin
          state_s = ST_FULL;
        end
      end
      ST_HOLD: begin
        if (byte_valid) begin
          bdrop_s = 1'b1;
        end else begin
          bdrop_s = 1'b0;
        end
        // A frame already under way at acknowledge time is never accepted.
        if (header_ack) begin
          valid_s = 1'b0;
          if (chip_enable) begin
            state_s = ST_IDLE;
          end else begin
            state_s = ST_DISCARD;
          end
        end else begin
          state_s = ST_HOLD;
        end
      end
      ST_DISCARD: begin
        if (chip_enable) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_DISCARD;
        end
      end
      default: begin
        state_s = ST_IDLE;
        valid_s = 1'b0;
      end
    endcase
  end

  // State and registered outputs, cleared asynchronously by rst_n.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= ST_IDLE;
      header_r <= '0;
      valid_r  <= 1'b0;
      ferr_r   <= 1'b0;
      bdrop_r  <= 1'b0;
      cnt_r    <= '0;
      fcnt_r   <= 8'd0;
    end else begin
      state_r  <= state_s;
      header_r <= header_s;
      valid_r  <= valid_s;
      ferr_r   <= ferr_s;
      bdrop_r  <= bdrop_s;
      cnt_r    <= cnt_s;
      fcnt_r   <= fcnt_s;
    end
  end

  assign header       = header_r;
  assign header_valid = valid_r;
  assign frame_error  = ferr_r;
  assign busy_drop    = bdrop_r;
  assign byte_count   = cnt_r;
  assign frame_count  = fcnt_r;

endmodule

// File: tb/tb_spi_header_assembler.sv
// Self-checking bench for spi_header_assembler: vector table of frame shapes,
// header scoreboard, and hand-written hold/discard/reset sequences.
module tb_spi_header_assembler;

  localparam int HB    = 80;
  localparam int CW    = 7;
  localparam int HDR_W = HB * 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              chip_enable;
  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              header_ack;
  logic [HDR_W-1:0]  header;
  logic              header_valid;
  logic              frame_error;
  logic              busy_drop;
  logic [CW-1:0]     byte_count;
  logic [7:0]        frame_count;

  spi_header_assembler #(.HEADER_BYTES(HB), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .chip_enable(chip_enable), .byte_valid(byte_valid),
    .byte_data(byte_data), .header_ack(header_ack), .header(header),
    .header_valid(header_valid), .frame_error(frame_error), .busy_drop(busy_drop),
    .byte_count(byte_count), .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int ferr_cnt  = 0;
  int bdrop_cnt = 0;
  int fc_exp    = 0;
  logic [HDR_W-1:0] exp_q[$];
  logic prev_ferr  = 1'b0;
  logic prev_valid = 1'b0;

  typedef struct {
    int       n;
    logic [7:0] base;
    bit       ce_last;
    bit       exp_valid;
    int       exp_ferr;
    int       exp_cnt;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [HDR_W-1:0] act, input logic [HDR_W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [HDR_W-1:0] build_exp(input int n, input logic [7:0] base);
    logic [HDR_W-1:0] e = '0;
    for (int i = 0; i < n; i++) e = {e[HDR_W-9:0], 8'(base + 8'(i))};
    return e;
  endfunction

  // Scoreboard/monitor: count pulses and compare header on each valid rise.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_ferr  = 1'b0;
      prev_valid = 1'b0;
    end else begin
      if (frame_error) begin
        ferr_cnt++;
        if (prev_ferr) begin
          total++;
          bad++;
          $display("FAIL ferr_double: frame_error high two cycles in a row");
        end
      end
      if (busy_drop) bdrop_cnt++;
      if (header_valid && !prev_valid) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_valid: header_valid rose with header %0h", header);
        end else begin
          logic [HDR_W-1:0] e;
          e = exp_q.pop_front();
          if (header !== e) begin
            bad++;
            $display("FAIL sb_header: got %0h expected %0h", header, e);
          end
        end
      end
      prev_ferr  = frame_error;
      prev_valid = header_valid;
    end
  end

  task automatic drive_frame(input int n, input logic [7:0] base, input bit ce_last, input bit push_exp);
    if (push_exp) exp_q.push_back(build_exp(n, base));
    chip_enable = 1'b0;
    tick();
    for (int i = 0; i < n; i++) begin
      byte_valid = 1'b1;
      byte_data  = 8'(base + 8'(i));
      if (ce_last && i == n - 1) chip_enable = 1'b1;
      tick();
    end
    byte_valid = 1'b0;
    if (!ce_last || n == 0) begin
      chip_enable = 1'b1;
      tick();
    end
    tick();
    tick();
  endtask

  task automatic do_ack();
    header_ack = 1'b1;
    tick();
    header_ack = 1'b0;
    tick();
  endtask

  initial begin
    int f0;
    int b0;
    logic [HDR_W-1:0] held;

    vecs[0] = '{80, 8'h00, 1'b0, 1'b1, 0, 80};
    vecs[1] = '{79, 8'h10, 1'b0, 1'b0, 1, 79};
    vecs[2] = '{81, 8'h20, 1'b0, 1'b0, 1, 80};
    vecs[3] = '{80, 8'h30, 1'b1, 1'b1, 0, 80};
    vecs[4] = '{1,  8'h55, 1'b0, 1'b0, 1, 1};
    vecs[5] = '{0,  8'h00, 1'b0, 1'b0, 1, 0};
    vecs[6] = '{79, 8'h60, 1'b1, 1'b0, 1, 79};
    vecs[7] = '{80, 8'hA0, 1'b0, 1'b1, 0, 80};

    rst_n       = 1'b1;
    chip_enable = 1'b1;
    byte_valid  = 1'b0;
    byte_data   = 8'h00;
    header_ack  = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("rst_header", header, '0);
    check("rst_valid", HDR_W'(header_valid), '0);
    check("rst_bcount", HDR_W'(byte_count), '0);
    check("rst_fcount", HDR_W'(frame_count), '0);
    check("rst_pulses", HDR_W'({frame_error, busy_drop}), '0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Table-driven frame shapes.
    for (int k = 0; k < 8; k++) begin
      f0 = ferr_cnt;
      drive_frame(vecs[k].n, vecs[k].base, vecs[k].ce_last, vecs[k].exp_valid);
      if (vecs[k].exp_valid) fc_exp++;
      check($sformatf("v%0d_ferr", k), HDR_W'(ferr_cnt - f0), HDR_W'(vecs[k].exp_ferr));
      check($sformatf("v%0d_valid", k), HDR_W'(header_valid), HDR_W'(vecs[k].exp_valid));
      check($sformatf("v%0d_fcount", k), HDR_W'(frame_count), HDR_W'(8'(fc_exp)));
      check($sformatf("v%0d_bcount", k), HDR_W'(byte_count), HDR_W'(vecs[k].exp_cnt));
      if (vecs[k].exp_valid) begin
        check($sformatf("v%0d_first", k), HDR_W'(header[HDR_W-1 -: 8]), HDR_W'(vecs[k].base));
        check($sformatf("v%0d_last", k), HDR_W'(header[7:0]), HDR_W'(8'(vecs[k].base + 8'd79)));
        do_ack();
        check($sformatf("v%0d_ack", k), HDR_W'(header_valid), '0);
      end
    end

    // Bytes arriving while the header is held, then ack with a frame open.
    drive_frame(80, 8'h11, 1'b0, 1'b1);
    fc_exp++;
    held = build_exp(80, 8'h11);
    b0 = bdrop_cnt;
    f0 = ferr_cnt;
    chip_enable = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      byte_valid = 1'b1;
      byte_data  = 8'(8'hE0 + 8'(i));
      tick();
    end
    byte_valid = 1'b0;
    tick();
    tick();
    check("hold_bdrop", HDR_W'(bdrop_cnt - b0), HDR_W'(5));
    check("hold_header", header, held);
    check("hold_valid", HDR_W'(header_valid), HDR_W'(1));
    do_ack();
    check("disc_valid", HDR_W'(header_valid), '0);
    b0 = bdrop_cnt;
    for (int i = 0; i < 80; i++) begin
      byte_valid = 1'b1;
      byte_data  = 8'(i);
      tick();
    end
    byte_valid = 1'b0;
    chip_enable = 1'b1;
    tick();
    tick();
    check("disc_quiet", HDR_W'((bdrop_cnt - b0) + (ferr_cnt - f0)), '0);
    check("disc_novalid", HDR_W'(header_valid), '0);
    header_ack = 1'b1;
    tick();
    header_ack = 1'b0;
    drive_frame(80, 8'h77, 1'b0, 1'b1);
    fc_exp++;
    check("fresh_valid", HDR_W'(header_valid), HDR_W'(1));
    check("fresh_fcount", HDR_W'(frame_count), HDR_W'(8'(fc_exp)));
    do_ack();

    // Asynchronous reset in the middle of a frame.
    chip_enable = 1'b0;
    tick();
    for (int i = 0; i < 40; i++) begin
      byte_valid = 1'b1;
      byte_data  = 8'(8'hC0 + 8'(i));
      tick();
    end
    byte_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_header", header, '0);
    check("mid_rst_bcount", HDR_W'(byte_count), '0);
    check("mid_rst_fcount", HDR_W'(frame_count), '0);
    check("mid_rst_valid", HDR_W'(header_valid), '0);
    tick();
    tick();
    rst_n = 1'b1;
    fc_exp = 0;
    drive_frame(80, 8'h40, 1'b0, 1'b1);
    fc_exp++;
    check("post_rst_valid", HDR_W'(header_valid), HDR_W'(1));
    check("post_rst_fcount", HDR_W'(frame_count), HDR_W'(8'(fc_exp)));
    do_ack();

    check("sb_drained", HDR_W'(exp_q.size()), '0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
